cu_mod0_1: RTL and testbench
============================

Name: cu_mod0_1

Overview:
- Control unit for FFT module 0, stage 1: the receiving end of the mod0 stage-0 → stage-1 alert handshake.
- Waits for the one-cycle alert_mod01 pulse from the stage-0 control unit, aligns to the incoming sample stream, and sequences the stage-1 BF2II butterfly (bf_en), its fac8 twiddle selector and its output valid.
- Regenerates the same alert protocol (alert_mod02) toward the next module.

Parameters:
- BLK_LEN, 32, cycles per butterfly block; power of two, ≥ 8.
- NUM_BLK, 16, blocks per frame; FRAME_LEN = BLK_LEN*NUM_BLK.
- DELAY, 2, alert-to-first-sample distance in cycles, used on both input and output side; 1 ≤ DELAY ≤ BLK_LEN/2.

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous active-low reset.
- alert_mod01  in  1  one-cycle pulse; first stage-0 valid sample arrives DELAY cycles later.
- bf_en  out  1  BF2II butterfly enable.
- sel_fac8  out  2  fac8_1 twiddle index.
- valid_fac8_1  out  1  stage-1 output sample valid.
- alert_mod02  out  1  one-cycle pulse to next module, DELAY cycles before first valid_fac8_1.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock, reset and outputs:
  - One clock; reset is synchronous and active-low (rstn sampled on posedge clk).
  - All outputs are decoded from registered state and counters only. There is no combinational path from alert_mod01 to any output.
  - Reset value: state = IDLE, all counters 0, all outputs 0.
  - Reset asserted mid-frame: IDLE and all outputs 0 from the next edge. The partial frame is abandoned and no alert_mod02 is issued.
- States: IDLE, WAIT, RUN, DRAIN.
- IDLE:
  - alert_mod01 high in cycle c → WAIT in cycle c+1.
  - If DELAY = 1, go directly to RUN in cycle c+1.
- WAIT:
  - dly_cnt counts DELAY-1 cycles, then RUN.
  - Net timing: cyc_cnt = 0 in cycle c+DELAY, aligned with the first upstream sample.
- RUN:
  - cyc_cnt runs 0..FRAME_LEN-1, +1 per cycle.
  - After FRAME_LEN-1 → DRAIN with drn_cnt = 0.
- DRAIN:
  - drn_cnt runs 0..BLK_LEN/2-1 (flushes the BF2II feedback), then IDLE.
- Output decode, with p = cyc_cnt mod BLK_LEN in RUN and p = drn_cnt in DRAIN:
  - bf_en = 1 in RUN when p ≥ BLK_LEN/2; 0 in DRAIN, WAIT and IDLE.
  - sel_fac8 = p div (BLK_LEN/4), 2 bits, in RUN and DRAIN; 0 otherwise.
  - valid_fac8_1 = 1 in RUN when cyc_cnt ≥ BLK_LEN/2, and for all of DRAIN. Exactly FRAME_LEN contiguous valid cycles per frame.
  - alert_mod02 = 1 only in the RUN cycle where cyc_cnt = BLK_LEN/2 - DELAY.
- Extra alerts: alert_mod01 arriving in WAIT, RUN or DRAIN is ignored; the frame in progress is not disturbed.
- Back-to-back frames: an alert in the first IDLE cycle after DRAIN is accepted normally.
- Counter widths: clog2 of their respective maximum+1. No wrap occurs except by the state transitions above.

Optional Feature:
- Macro CU_MOD0_1_OVR_EN.
- Defined:
  - Extra output port err_overrun (1 bit).
  - Set to 1 the cycle after alert_mod01 is seen in WAIT, RUN or DRAIN.
  - Sticky; cleared only by rstn.
- Not defined: port absent; extra alerts silently ignored.

Test Plan (defaults BLK_LEN=32, NUM_BLK=16, DELAY=2; alert_mod01 pulsed in cycle 0):
- Single frame:
  - busy high for cycles 1..529.
  - RUN covers cycles 2..513; DRAIN covers 514..529; IDLE from 530.
  - valid_fac8_1 high exactly in cycles 18..529 (512 cycles).
  - alert_mod02 pulses only in cycle 16.
- bf_en and sel_fac8 in the same frame:
  - bf_en high in cycles 18..33, 50..65, …, 498..513; low in 514..529.
  - sel_fac8 = 0,1,2,3 over cycles 2–9, 10–17, 18–25 and 26–33, repeating every 32 cycles.
  - sel_fac8 = 0 over 514–521 and 1 over 522–529.
- Overrun:
  - Second alert_mod01 in cycle 100 → all outputs identical to the single-frame case.
  - With CU_MOD0_1_OVR_EN: err_overrun = 1 from cycle 101 until reset.
- Reset mid-frame: rstn low in cycle 200 → busy, bf_en and valid_fac8_1 all 0 from cycle 201. A new alert after rstn is released reproduces the single-frame timeline.
- Back-to-back: second alert in cycle 530 → second frame valid in cycles 548..1059 and alert_mod02 in cycle 546.
- DELAY=1 rebuild: alert in cycle 0 → RUN starts in cycle 1, alert_mod02 in cycle 16, valid_fac8_1 in cycles 17..528.

Source files
------------

// File: rtl/cu_mod0_1.sv
// Stage-1 control unit for FFT module 0: receives the stage-0 alert, sequences BF2II/fac8_1 and re-issues the alert downstream.
// Define CU_MOD0_1_OVR_EN to add the sticky err_overrun output flagging alerts that arrive while a frame is in progress.
module cu_mod0_1 #(
   parameter int BLK_LEN = 32,
   parameter int NUM_BLK = 16,
   parameter int DELAY   = 2
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       alert_mod01,
   output logic       bf_en,
   output logic [1:0] sel_fac8,
   output logic       valid_fac8_1,
   output logic       alert_mod02,
   output logic       busy
`ifdef CU_MOD0_1_OVR_EN
   ,
   output logic       err_overrun
`endif
);

   localparam int FRAME_LEN = BLK_LEN * NUM_BLK;
   localparam int HALF      = BLK_LEN / 2;
   localparam int PW        = $clog2(BLK_LEN);
   localparam int CYC_W     = $clog2(FRAME_LEN);
   localparam int DRN_W     = $clog2(HALF);
   localparam int DLY_W     = (DELAY > 1) ? $clog2(DELAY) : 1;

   localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(FRAME_LEN - 1);
   localparam logic [CYC_W-1:0] CYC_HALF = CYC_W'(HALF);
   localparam logic [CYC_W-1:0] A2_POS   = CYC_W'(HALF - DELAY);
   localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(HALF - 1);
   localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'((DELAY > 1) ? (DELAY - 2) : 0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CYC_W-1:0]   cyc_q, cyc_d;
   logic [DRN_W-1:0]   drn_q, drn_d;
   logic [DLY_W-1:0]   dly_q, dly_d;
   logic [PW-1:0]      pos_d;

   logic               bf_en_q, bf_en_d;
   logic [1:0]         sel_q, sel_d;
   logic               vld_q, vld_d;
   logic               a2_q, a2_d;
   logic               busy_q, busy_d;
`ifdef CU_MOD0_1_OVR_EN
   logic               err_q, err_d;
`endif

   // Next-state and counter sequencing
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      drn_d   = drn_q;
      dly_d   = dly_q;
      case (state_q)
         ST_IDLE: begin
            if (alert_mod01) begin
               if (DELAY == 1) begin
                  state_d = ST_RUN;
                  cyc_d   = '0;
               end else begin
                  state_d = ST_WAIT;
                  dly_d   = '0;
               end
            end
         end
         ST_WAIT: begin
            if (dly_q == DLY_LAST) begin
               state_d = ST_RUN;
               cyc_d   = '0;
            end else begin
               dly_d = dly_q + 1'b1;
            end
         end
         ST_RUN: begin
            if (cyc_q == CYC_LAST) begin
               state_d = ST_DRAIN;
               drn_d   = '0;
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (drn_q == DRN_LAST) begin
               state_d = ST_IDLE;
            end else begin
               drn_d = drn_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registered copies line up with the state they describe
   always_comb begin
      pos_d = '0;
      if (state_d == ST_RUN) begin
         pos_d = cyc_d[PW-1:0];
      end else if (state_d == ST_DRAIN) begin
         pos_d = PW'(drn_d);
      end
      bf_en_d = (state_d == ST_RUN) && pos_d[PW-1];
      sel_d   = ((state_d == ST_RUN) || (state_d == ST_DRAIN)) ? pos_d[PW-1 -: 2] : 2'd0;
      vld_d   = ((state_d == ST_RUN) && (cyc_d >= CYC_HALF)) || (state_d == ST_DRAIN);
      a2_d    = (state_d == ST_RUN) && (cyc_d == A2_POS);
      busy_d  = (state_d != ST_IDLE);
   end

`ifdef CU_MOD0_1_OVR_EN
   always_comb begin
      err_d = err_q | (alert_mod01 && (state_q != ST_IDLE));
   end
`endif

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         cyc_q   <= '0;
         drn_q   <= '0;
         dly_q   <= '0;
         bf_en_q <= 1'b0;
         sel_q   <= 2'd0;
         vld_q   <= 1'b0;
         a2_q    <= 1'b0;
         busy_q  <= 1'b0;
`ifdef CU_MOD0_1_OVR_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         drn_q   <= drn_d;
         dly_q   <= dly_d;
         bf_en_q <= bf_en_d;
         sel_q   <= sel_d;
         vld_q   <= vld_d;
         a2_q    <= a2_d;
         busy_q  <= busy_d;
`ifdef CU_MOD0_1_OVR_EN
         err_q   <= err_d;
`endif
      end
   end

   assign bf_en        = bf_en_q;
   assign sel_fac8     = sel_q;
   assign valid_fac8_1 = vld_q;
   assign alert_mod02  = a2_q;
   assign busy         = busy_q;
`ifdef CU_MOD0_1_OVR_EN
   assign err_overrun  = err_q;
`endif

endmodule

// File: tb/tb_cu_mod0_1.sv
// Bench for cu_mod0_1: cycle-timeline scoreboard plus constant spot-check tables for the single-frame schedule.
module tb_cu_mod0_1;

   localparam int BLK_LEN   = 32;
   localparam int NUM_BLK   = 16;
   localparam int DELAY     = 2;
   localparam int FRAME_LEN = BLK_LEN * NUM_BLK;
   localparam int HALF      = BLK_LEN / 2;
   localparam int QTR       = BLK_LEN / 4;
   localparam int RUN_END   = DELAY + FRAME_LEN - 1;
   localparam int END_R     = RUN_END + HALF;
   localparam int HMAX      = 4096;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       alert_mod01 = 1'b0;
   logic       bf_en;
   logic [1:0] sel_fac8;
   logic       valid_fac8_1;
   logic       alert_mod02;
   logic       busy;
   logic       err_obs;

   always #5 clk = ~clk;

`ifdef CU_MOD0_1_OVR_EN
   logic err_overrun;
   assign err_obs = err_overrun;
`else
   assign err_obs = 1'b0;
`endif

   cu_mod0_1 #(.BLK_LEN(BLK_LEN), .NUM_BLK(NUM_BLK), .DELAY(DELAY)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .alert_mod01  (alert_mod01),
      .bf_en        (bf_en),
      .sel_fac8     (sel_fac8),
      .valid_fac8_1 (valid_fac8_1),
      .alert_mod02  (alert_mod02),
      .busy         (busy)
`ifdef CU_MOD0_1_OVR_EN
      ,
      .err_overrun  (err_overrun)
`endif
   );

   typedef struct packed {
      logic       busy;
      logic       bf;
      logic [1:0] sel;
      logic       vld;
      logic       a2;
      logic       err;
   } out_t;

   typedef struct {
      int   cyc;
      out_t o;
   } sb_t;

   typedef struct {
      int         k;
      logic       busy;
      logic       bf;
      logic [1:0] sel;
      logic       vld;
      logic       a2;
   } vec_t;

   sb_t  sbq[$];
   out_t hist [0:HMAX-1];
   vec_t vec [0:19];
   int   checks = 0;
   int   errors = 0;
   int   t = 0;
   int   frame_start = -1;
   logic err_m = 1'b0;

   // Expected outputs for cycle tc from the frame timeline relative to the accepted alert
   function automatic out_t model(input int tc);
      out_t o;
      int   r, k, d;
      o = '0;
      o.err = err_m;
      if (frame_start >= 0) begin
         r = tc - frame_start;
         if (r >= 1 && r <= END_R) begin
            o.busy = 1'b1;
            if (r >= DELAY && r <= RUN_END) begin
               k     = r - DELAY;
               o.bf  = (k % BLK_LEN) >= HALF;
               o.sel = 2'((k % BLK_LEN) / QTR);
               o.vld = (k >= HALF);
               o.a2  = (k == HALF - DELAY);
            end else if (r > RUN_END) begin
               d     = r - RUN_END - 1;
               o.sel = 2'(d / QTR);
               o.vld = 1'b1;
            end
         end
      end
      return o;
   endfunction

   task automatic step(input logic a, input logic rn);
      out_t e;
      sb_t  s;
      @(posedge clk);
      #1;
      alert_mod01 = a;
      rstn        = rn;
      e     = model(t);
      s.cyc = t;
      s.o   = e;
      sbq.push_back(s);
      if (!rn) begin
         frame_start = -1;
         err_m       = 1'b0;
      end else if (a) begin
`ifdef CU_MOD0_1_OVR_EN
         if (e.busy) err_m = 1'b1;
`endif
         if (!e.busy) frame_start = t;
      end
      t++;
   endtask

   task automatic flush();
      @(negedge clk);
      #1;
   endtask

   always @(negedge clk) begin : mon
      sb_t  s;
      out_t a;
      if (sbq.size() > 0) begin
         s = sbq.pop_front();
         a = {busy, bf_en, sel_fac8, valid_fac8_1, alert_mod02, err_obs};
         if (s.cyc < HMAX) hist[s.cyc] = a;
         checks++;
         if (a !== s.o) begin
            errors++;
            $display("FAIL cycle %0d outputs {busy,bf_en,sel,valid,alert2,err}: got %b, expected %b",
                     s.cyc, a, s.o);
         end
      end
   end

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic check_table(input int base, input string tag);
      out_t h;
      for (int i = 0; i < 20; i++) begin
         h = hist[base + vec[i].k];
         checks++;
         if ({h.busy, h.bf, h.sel, h.vld, h.a2} !==
             {vec[i].busy, vec[i].bf, vec[i].sel, vec[i].vld, vec[i].a2}) begin
            errors++;
            $display("FAIL %s k=%0d {busy,bf_en,sel,valid,alert2}: got %b, expected %b", tag, vec[i].k,
                     {h.busy, h.bf, h.sel, h.vld, h.a2},
                     {vec[i].busy, vec[i].bf, vec[i].sel, vec[i].vld, vec[i].a2});
         end
      end
   endtask

   initial begin
      int b1, b2, b3, b4, b5;
      //            k    busy  bf    sel   vld   a2
      vec[0]  = '{  0,   1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
      vec[1]  = '{  1,   1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
      vec[2]  = '{  2,   1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
      vec[3]  = '{  9,   1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
      vec[4]  = '{ 10,   1'b1, 1'b0, 2'd1, 1'b0, 1'b0};
      vec[5]  = '{ 15,   1'b1, 1'b0, 2'd1, 1'b0, 1'b0};
      vec[6]  = '{ 16,   1'b1, 1'b0, 2'd1, 1'b0, 1'b1};
      vec[7]  = '{ 17,   1'b1, 1'b0, 2'd1, 1'b0, 1'b0};
      vec[8]  = '{ 18,   1'b1, 1'b1, 2'd2, 1'b1, 1'b0};
      vec[9]  = '{ 26,   1'b1, 1'b1, 2'd3, 1'b1, 1'b0};
      vec[10] = '{ 33,   1'b1, 1'b1, 2'd3, 1'b1, 1'b0};
      vec[11] = '{ 34,   1'b1, 1'b0, 2'd0, 1'b1, 1'b0};
      vec[12] = '{ 50,   1'b1, 1'b1, 2'd2, 1'b1, 1'b0};
      vec[13] = '{498,   1'b1, 1'b1, 2'd2, 1'b1, 1'b0};
      vec[14] = '{513,   1'b1, 1'b1, 2'd3, 1'b1, 1'b0};
      vec[15] = '{514,   1'b1, 1'b0, 2'd0, 1'b1, 1'b0};
      vec[16] = '{521,   1'b1, 1'b0, 2'd0, 1'b1, 1'b0};
      vec[17] = '{522,   1'b1, 1'b0, 2'd1, 1'b1, 1'b0};
      vec[18] = '{529,   1'b1, 1'b0, 2'd1, 1'b1, 1'b0};
      vec[19] = '{530,   1'b0, 1'b0, 2'd0, 1'b0, 1'b0};

      repeat (3) step(1'b0, 1'b0);
      flush();
      chk("reset outputs", 8'(hist[t-1]), 8'h00);

      b1 = t;
      step(1'b1, 1'b1);
      repeat (539) step(1'b0, 1'b1);
      check_table(b1, "single");

      // Spurious alert mid-frame must not disturb the timeline
      b2 = t;
      step(1'b1, 1'b1);
      for (int k = 1; k < 540; k++) step(k == 100, 1'b1);
      check_table(b2, "overrun");
`ifdef CU_MOD0_1_OVR_EN
      chk("err before overrun", 8'(hist[b2+100].err), 8'h00);
      chk("err after overrun", 8'(hist[b2+101].err), 8'h01);
      chk("err sticky", 8'(hist[b2+539].err), 8'h01);
`endif
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      flush();
      chk("err cleared by reset", 8'(hist[t-1].err), 8'h00);

      // Reset mid-frame, then a fresh frame
      b3 = t;
      step(1'b1, 1'b1);
      for (int k = 1; k < 210; k++) step(1'b0, k != 200);
      chk("busy before reset", 8'(hist[b3+200].busy), 8'h01);
      chk("reset mid-frame busy/bf/valid",
          8'({hist[b3+201].busy, hist[b3+201].bf, hist[b3+201].vld}), 8'h00);
      chk("no alert2 after reset", 8'(hist[b3+209].a2), 8'h00);
      b4 = t;
      step(1'b1, 1'b1);
      repeat (539) step(1'b0, 1'b1);
      check_table(b4, "post-reset");

      // Back-to-back frames
      b5 = t;
      step(1'b1, 1'b1);
      for (int k = 1; k < 1070; k++) step(k == 530, 1'b1);
      check_table(b5, "b2b-first");
      chk("b2b alert2 @545", 8'(hist[b5+545].a2), 8'h00);
      chk("b2b alert2 @546", 8'(hist[b5+546].a2), 8'h01);
      chk("b2b valid @547", 8'(hist[b5+547].vld), 8'h00);
      chk("b2b valid @548", 8'(hist[b5+548].vld), 8'h01);
      chk("b2b valid @1059", 8'(hist[b5+1059].vld), 8'h01);
      chk("b2b valid @1060", 8'(hist[b5+1060].vld), 8'h00);

      repeat (2) step(1'b0, 1'b1);
      flush();
      chk("scoreboard drained", 8'(sbq.size()), 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
